// File: rtl/instruction_encoder_loader.sv
// Program loader: packs MIPS R/I/J fields into 32-bit words and streams them into instruction memory.
// Optional FIELD_CHECK_EN rejects malformed bundles and exposes err/err_count.
module instruction_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op_code,
  input  logic [4:0]        rs_add,
  input  logic [4:0]        rt_add,
  input  logic [4:0]        rd_add,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  // 'const' is a reserved word, so the immediate field carries a suffix
  input  logic [15:0]       const_val,
  input  logic [25:0]       j_add,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              full,
  output logic              done
`ifdef FIELD_CHECK_EN
  ,
  output logic              err,
  output logic [7:0]        err_count
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              xfer, bad, wr, last, session_start;

  assign in_ready      = (state == ACTIVE) && !full;
  assign busy          = (state == ACTIVE);
  assign done          = (state == DONE);
  assign xfer          = in_valid && in_ready;
  assign session_start = (state != ACTIVE) && start;

`ifdef FIELD_CHECK_EN
  assign bad = (fmt == 2'd3) || ((fmt == 2'd0) && (op_code != 6'd0));
`else
  assign bad = 1'b0;
`endif

  assign wr   = xfer && !bad;
  assign last = wr && (word_count == DEPTH_C - (ADDR_W+1)'(1));

  // Reserved format falls through to R packing when unchecked
  always_comb begin
    word = {op_code, rs_add, rt_add, rd_add, shamt, func};
    case (fmt)
      2'd1:    word = {op_code, rs_add, rt_add, const_val};
      2'd2:    word = {op_code, j_add};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE:  if (finish || last) state_nxt = DONE;
      DONE:    if (start) state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      full       <= 1'b0;
      ptr        <= BASE_C;
    end else begin
      mem_we <= wr;
      if (wr) begin
        mem_addr  <= ptr;
        mem_wdata <= word;
      end
      if (session_start) begin
        ptr        <= BASE_C;
        word_count <= '0;
        full       <= 1'b0;
      end else if (wr) begin
        ptr        <= ptr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
        if (last) full <= 1'b1;
      end
    end
  end

`ifdef FIELD_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= xfer && bad;
      if (session_start)                        err_count <= '0;
      else if (xfer && bad && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
